// File: rtl/neighbour_min_sqdiff_if.sv
// Window request, neighbour stream and result bundle for neighbour_min_sqdiff.
interface neighbour_min_sqdiff_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned NBR   = 8
);
    localparam int unsigned E_W   = 2 * PIX_W;
    localparam int unsigned IDX_W = $clog2(NBR);

    logic             start;
    logic [PIX_W-1:0] in_center;
    logic [E_W-1:0]   thresh;
    logic             tgt_valid;
    logic [PIX_W-1:0] in_target;
    logic             tgt_ready;
    logic             busy;
    logic             done;
    logic [E_W-1:0]   e_min;
    logic [IDX_W-1:0] e_idx;
    logic             corner;

    modport master (
        output start, in_center, thresh, tgt_valid, in_target,
        input  tgt_ready, busy, done, e_min, e_idx, corner
    );

    modport slave (
        input  start, in_center, thresh, tgt_valid, in_target,
        output tgt_ready, busy, done, e_min, e_idx, corner
    );
endinterface

// File: rtl/neighbour_min_sqdiff.sv
// Minimum squared difference between a centre pixel and NBR neighbours,
// with arrival index of the minimum and a corner flag against a threshold.
module neighbour_min_sqdiff #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned NBR   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    neighbour_min_sqdiff_if.slave  bus
);
    localparam int unsigned E_W   = 2 * PIX_W;
    localparam int unsigned IDX_W = $clog2(NBR);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [PIX_W-1:0] center_q;
    logic [E_W-1:0]   thresh_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s1_valid_q;
    logic             s1_last_q;
    logic [E_W-1:0]   s1_sq_q;
    logic [IDX_W-1:0] s1_idx_q;

    logic [E_W-1:0]   min_q;
    logic [IDX_W-1:0] ridx_q;

    logic             done_q;
    logic [E_W-1:0]   e_min_q;
    logic [IDX_W-1:0] e_idx_q;
    logic             corner_q;

    logic             start_ok_c;
    logic             accept_c;
    logic             last_c;
    logic             fin_c;
    logic             upd_c;
    logic [PIX_W-1:0] diff_c;
    logic [E_W-1:0]   sq_c;
    logic [E_W-1:0]   min_nxt_c;
    logic [IDX_W-1:0] idx_nxt_c;

    // Handshake qualifiers; a start only counts when no window is running.
    always_comb begin
        start_ok_c = bus.start && (state_q == IDLE);
        accept_c   = bus.tgt_valid && ready_q;
        last_c     = (cnt_q == CNT_W'(NBR - 1));
        fin_c      = s1_valid_q && s1_last_q;
    end

    // Absolute difference and full-width square, never truncated.
    always_comb begin
        diff_c = (bus.in_target >= center_q) ? (bus.in_target - center_q)
                                             : (center_q - bus.in_target);
        sq_c   = E_W'(diff_c) * E_W'(diff_c);
    end

    // Strict-less compare so ties keep the earliest arrival.
    always_comb begin
        upd_c     = s1_valid_q && (s1_sq_q < min_q);
        min_nxt_c = upd_c ? s1_sq_q : min_q;
        idx_nxt_c = upd_c ? s1_idx_q : ridx_q;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok_c)         state_d = SCAN;
            SCAN:    if (accept_c && last_c) state_d = FLUSH;
            FLUSH:   if (fin_c)              state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so the flops track the state.
    always_comb begin
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == SCAN);
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Window context, neighbour counter and running minimum (stage 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            center_q <= '0;
            thresh_q <= '0;
            cnt_q    <= '0;
            min_q    <= '1;
            ridx_q   <= '0;
        end else if (start_ok_c) begin
            center_q <= bus.in_center;
            thresh_q <= bus.thresh;
            cnt_q    <= '0;
            min_q    <= '1;
            ridx_q   <= '0;
        end else begin
            if (accept_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (s1_valid_q) begin
                min_q  <= min_nxt_c;
                ridx_q <= idx_nxt_c;
            end
        end
    end

    // Stage 1: capture the square and its arrival index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sq_q    <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_last_q <= last_c;
                s1_sq_q   <= sq_c;
                s1_idx_q  <= cnt_q[IDX_W-1:0];
            end
        end
    end

    // Result registers: loaded with the final minimum, held until the next window ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            e_min_q  <= '0;
            e_idx_q  <= '0;
            corner_q <= 1'b0;
        end else begin
            done_q <= fin_c;
            if (fin_c) begin
                e_min_q  <= min_nxt_c;
                e_idx_q  <= idx_nxt_c;
                corner_q <= (min_nxt_c > thresh_q);
            end
        end
    end

    assign bus.tgt_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.e_min     = e_min_q;
    assign bus.e_idx     = e_idx_q;
    assign bus.corner    = corner_q;
endmodule
